// File: rtl/regfile_scan_reader.sv
// regfile_scan_reader
// Read-side scanner for a 2^ADDR_W x DATA_W register file. It drives the read
// address, either sweeping on a dwell timer or stepping on a debounced key
// edge. It captures the returned data for the hex display path and keeps that
// data refreshed every cycle while a register is being shown.
module regfile_scan_reader #(
  parameter int DWELL  = 50000000,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mode_auto,
  input  logic              step,
  input  logic              dir,
  output logic [ADDR_W-1:0] readaddr,
  input  logic [DATA_W-1:0] readdata,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              wrap
);

  localparam int                CNT_W      = $clog2(DWELL);
  localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_MAX   = {ADDR_W{1'b1}};
  localparam logic [DATA_W-1:0] DATA_ZERO  = {DATA_W{1'b0}};

  // SET_ADDR: address is on the read port, let the file settle one cycle.
  // SAMPLE  : capture address and data together, display becomes valid.
  // SHOW    : keep refreshing the data until the next advance.
  typedef enum logic [1:0] {
    ST_SET_ADDR = 2'b00,
    ST_SAMPLE   = 2'b01,
    ST_SHOW     = 2'b10
  } state_t;

  state_t              state_q,      state_d;
  logic [ADDR_W-1:0]   readaddr_q,   readaddr_d;
  logic [ADDR_W-1:0]   disp_addr_q,  disp_addr_d;
  logic [DATA_W-1:0]   disp_data_q,  disp_data_d;
  logic                disp_valid_q, disp_valid_d;
  logic                wrap_q,       wrap_d;
  logic [CNT_W-1:0]    dwell_q,      dwell_d;
  logic                s1_q,         s1_d;
  logic                s2_q,         s2_d;
  logic                s3_q,         s3_d;
  logic                mode_prev_q,  mode_prev_d;

  logic step_edge;
  logic mode_chg;
  logic dwell_done;
  logic advance;

  // Key synchronizer chain and mode history for change detection.
  always_comb begin
    s1_d        = step;
    s2_d        = s1_q;
    s3_d        = s2_q;
    mode_prev_d = mode_auto;
  end

  // Scan sequencing: next state, address stepping, display capture, dwell timing.
  always_comb begin
    state_d      = state_q;
    readaddr_d   = readaddr_q;
    disp_addr_d  = disp_addr_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = disp_valid_q;
    wrap_d       = 1'b0;
    dwell_d      = dwell_q;

    step_edge  = s2_q & ~s3_q;
    mode_chg   = mode_auto ^ mode_prev_q;
    dwell_done = mode_auto & (dwell_q == DWELL_LAST);
    // A key edge and a dwell expiry in the same cycle still give one advance.
    advance    = step_edge | dwell_done;

    case (state_q)
      ST_SET_ADDR: begin
        // Key edges landing here are intentionally dropped.
        disp_valid_d = 1'b0;
        dwell_d      = CNT_ZERO;
        state_d      = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        disp_data_d  = readdata;
        disp_addr_d  = readaddr_q;
        disp_valid_d = 1'b1;
        dwell_d      = CNT_ZERO;
        state_d      = ST_SHOW;
      end
      ST_SHOW: begin
        // Live refresh so writes to the shown register appear next cycle.
        disp_data_d = readdata;
        if (advance) begin
          if (dir) begin
            readaddr_d = readaddr_q + ADDR_ONE;
            wrap_d     = (readaddr_q == ADDR_MAX);
          end else begin
            readaddr_d = readaddr_q - ADDR_ONE;
            wrap_d     = (readaddr_q == ADDR_ZERO);
          end
          disp_valid_d = 1'b0;
          dwell_d      = CNT_ZERO;
          state_d      = ST_SET_ADDR;
        end else if (mode_chg) begin
          dwell_d = CNT_ZERO;
        end else if (mode_auto) begin
          dwell_d = dwell_q + CNT_ONE;
        end else begin
          dwell_d = CNT_ZERO;
        end
      end
      default: begin
        disp_valid_d = 1'b0;
        dwell_d      = CNT_ZERO;
        state_d      = ST_SET_ADDR;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_SET_ADDR;
      readaddr_q   <= ADDR_ZERO;
      disp_addr_q  <= ADDR_ZERO;
      disp_data_q  <= DATA_ZERO;
      disp_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
      dwell_q      <= CNT_ZERO;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      mode_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      readaddr_q   <= readaddr_d;
      disp_addr_q  <= disp_addr_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      wrap_q       <= wrap_d;
      dwell_q      <= dwell_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      mode_prev_q  <= mode_prev_d;
    end
  end

  assign readaddr   = readaddr_q;
  assign disp_addr  = disp_addr_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Bench for regfile_scan_reader: register file modelled as an array, outputs
// compared every cycle with a cycle-count based reference model, plus a
// vector table and directed corner-case sequences.
module tb_regfile_scan_reader;

  localparam int DWELL = 4;
  localparam int N     = 32;

  logic        clk = 1'b0;
  logic        reset_n, mode_auto, step, dir;
  logic [4:0]  readaddr, disp_addr;
  logic [31:0] readdata, disp_data;
  logic        disp_valid, wrap;
  logic [31:0] mem [N];

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_addr, m_since, m_dwell;
  bit          m_mode_prev;
  bit   [2:0]  m_hist;       // [0] = step value sampled at the latest edge
  logic [4:0]  m_daddr;
  logic [31:0] m_ddata;
  bit          m_valid, m_wrap;

  int cyc = 0;
  int wrap_cnt = 0;
  int k, rises, last, nfall;
  logic pv;
  logic [4:0]  ea;
  logic [31:0] ed;

  typedef struct {
    bit         d;
    int         pulse;
    logic [4:0] exp_addr;
    int         exp_wraps;
  } vec_t;
  vec_t tbl [5];

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  assign readdata = mem[readaddr];

  regfile_scan_reader #(.DWELL(DWELL), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .mode_auto(mode_auto), .step(step), .dir(dir),
    .readaddr(readaddr), .readdata(readdata), .disp_addr(disp_addr),
    .disp_data(disp_data), .disp_valid(disp_valid), .wrap(wrap)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = 0; m_since = 0; m_dwell = 0; m_mode_prev = 1'b0; m_hist = 3'b000;
    m_daddr = 5'd0; m_ddata = 32'd0; m_valid = 1'b0; m_wrap = 1'b0;
  endtask

  // One clock: predict from the rules, advance clock, compare all outputs.
  task automatic tick();
    bit ke, adv;
    int nxt;
    ke = m_hist[1] & ~m_hist[2];
    m_wrap = 1'b0;
    if (m_since == 0) begin
      m_since = 1; m_dwell = 0;
    end else if (m_since == 1) begin
      m_daddr = m_addr[4:0]; m_ddata = mem[m_addr]; m_valid = 1'b1; m_dwell = 0; m_since = 2;
    end else begin
      m_ddata = mem[m_addr];
      adv = ke || (mode_auto && m_dwell == DWELL - 1);
      if (adv) begin
        nxt    = ((dir ? m_addr + 1 : m_addr - 1) + N) % N;
        m_wrap = dir ? (m_addr == N - 1) : (m_addr == 0);
        m_addr = nxt; m_valid = 1'b0; m_since = 0; m_dwell = 0;
      end else if (mode_auto != m_mode_prev) m_dwell = 0;
      else if (mode_auto) m_dwell = m_dwell + 1;
      else m_dwell = 0;
    end
    m_mode_prev = mode_auto;
    m_hist = {m_hist[1:0], step};
    @(posedge clk); #1;
    cyc++;
    if (wrap) wrap_cnt++;
    check("cycle", {readaddr, disp_addr, disp_data, disp_valid, wrap},
          {m_addr[4:0], m_daddr, m_ddata, m_valid, m_wrap});
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check("async_reset", {readaddr, disp_addr, disp_data, disp_valid, wrap}, 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1; mode_auto = 1'b0; step = 1'b0; dir = 1'b1;
    for (int i = 0; i < N; i++) mem[i] = i * 32'h01010101;
    tbl[0] = '{1'b1, 1, 5'd0,  1};
    tbl[1] = '{1'b1, 4, 5'd1,  0};
    tbl[2] = '{1'b0, 2, 5'd0,  0};
    tbl[3] = '{1'b0, 3, 5'd31, 1};
    tbl[4] = '{1'b0, 1, 5'd30, 0};

    // reset and first sample
    do_reset();
    tick(); tick();
    check("rst_show", {disp_valid, disp_addr, disp_data}, {1'b1, 5'd0, mem[0]});

    // auto scan, period DWELL+2
    mode_auto = 1'b1; dir = 1'b1;
    rises = 0; last = -1; k = 0; pv = disp_valid; ea = 5'd1;
    while (rises < 5 && k < 200) begin
      tick(); k++;
      if (disp_valid && !pv) begin
        ed = {27'd0, ea} * 32'h01010101;
        check("auto_addr", disp_addr, ea);
        check("auto_data", disp_data, ed);
        if (last >= 0) check("auto_period", cyc - last, DWELL + 2);
        last = cyc; ea = ea + 5'd1; rises++;
      end
      pv = disp_valid;
    end
    check("auto_rises", rises, 5);
    check("auto_nowrap", wrap_cnt, 0);

    // wrap upward 31 -> 0
    k = 0;
    while (!(disp_valid && disp_addr == 5'd31) && k < 300) begin tick(); k++; end
    check("reach31", {disp_valid, disp_addr}, {1'b1, 5'd31});
    wrap_cnt = 0; k = 0; pv = disp_valid;
    while (!(disp_valid && !pv) && k < 20) begin pv = disp_valid; tick(); k++; end
    check("wrapup_addr", {disp_valid, disp_addr, disp_data}, {1'b1, 5'd0, 32'h00000000});
    check("wrapup_pulses", wrap_cnt, 1);

    // manual down-step, long key hold, then long idle
    mode_auto = 1'b0; dir = 1'b0; wrap_cnt = 0; nfall = 0; pv = disp_valid;
    step = 1'b1;
    for (int i = 0; i < 1010; i++) begin
      if (i == 10) step = 1'b0;
      tick();
      if (!disp_valid && pv) nfall++;
      pv = disp_valid;
    end
    check("down_addr", disp_addr, 5'd31);
    check("down_wraps", wrap_cnt, 1);
    check("down_advances", nfall, 1);

    // vector table of manual steps
    for (int v = 0; v < 5; v++) begin
      dir = tbl[v].d; wrap_cnt = 0;
      step = 1'b1;
      for (int i = 0; i < tbl[v].pulse; i++) tick();
      step = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check("vec_addr", {disp_valid, disp_addr}, {1'b1, tbl[v].exp_addr});
      check("vec_wraps", wrap_cnt, tbl[v].exp_wraps);
    end

    // live refresh at address 30
    mem[30] = 32'h0003FFFF; tick();
    check("refresh_a", disp_data, 32'h0003FFFF);
    mem[30] = 32'h00012345; tick();
    check("refresh_b", {disp_valid, disp_addr, disp_data}, {1'b1, 5'd30, 32'h00012345});

    // key edge colliding with dwell expiry -> single advance
    mode_auto = 1'b1; dir = 1'b1; k = 0;
    tick();
    while (!(m_since >= 2 && m_dwell == 1) && k < 20) begin tick(); k++; end
    check("collide_sync", m_dwell, 1);
    step = 1'b1;
    tick(); tick(); tick();
    check("collide_fall", disp_valid, 1'b0);
    step = 1'b0;
    tick(); tick();
    check("collide_addr", {disp_valid, disp_addr}, {1'b1, 5'd31});
    tick(); tick();
    check("collide_hold", {disp_valid, disp_addr}, {1'b1, 5'd31});

    // key edge landing in SET_ADDR is dropped
    k = 0;
    while (!(m_since >= 2 && m_dwell == 2) && k < 20) begin tick(); k++; end
    check("drop_sync", m_dwell, 2);
    step = 1'b1;
    tick(); tick();
    step = 1'b0;
    tick(); tick();
    check("drop_addr", {disp_valid, disp_addr}, {1'b1, 5'd0});
    tick(); tick(); tick();
    check("drop_hold", {disp_valid, disp_addr}, {1'b1, 5'd0});

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49, 0) == 0) mode_auto = ~mode_auto;
      if ($urandom_range(7, 0) == 0)  dir = $urandom_range(1, 0);
      if ($urandom_range(5, 0) == 0)  step = ~step;
      if ($urandom_range(19, 0) == 0) mem[$urandom_range(N-1, 0)] = $urandom;
      if ($urandom_range(799, 0) == 0) do_reset();
      tick();
    end

    // reset in SHOW at address 7
    mode_auto = 1'b1; dir = 1'b1; step = 1'b0; k = 0;
    while (!(m_addr == 7 && m_since >= 2) && k < 400) begin tick(); k++; end
    check("reach7", {disp_valid, disp_addr}, {1'b1, 5'd7});
    do_reset();
    check("rst_readaddr", readaddr, 5'd0);
    tick(); tick();
    check("rst7_show", {disp_valid, disp_addr, disp_data}, {1'b1, 5'd0, mem[0]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scan_reader.md
Name: regfile_scan_reader

Overview:
- Read-side companion to the 32x32 register file board harness. The harness only writes.
- This block drives the file's read-address port, sweeping every register automatically or stepping through them on a key press.
- It registers the returned read data and the current address for the hex display path, with live refresh.
- It sits between reg32x32 (readaddr/readdata) and the Hex7Seg display instances at board top level.

Parameters:
- DWELL, 50000000: clk cycles each register is shown in auto mode; minimum 2.
- ADDR_W, 5: register address width; the file holds 2^ADDR_W entries.
- DATA_W, 32: register data width.

Ports:
- clk  input  1  system clock (CLOCK_50 at top level).
- reset_n  input  1  asynchronous, active-low reset.
- mode_auto  input  1  1 = timed auto scan; 0 = manual step only. Quasi-static (switch).
- step  input  1  asynchronous push-button level, active high. Synchronized internally.
- dir  input  1  1 = increment address; 0 = decrement. Sampled at each advance.
- readaddr  output  ADDR_W  registered address to the register file read port.
- readdata  input  DATA_W  combinational read data from the register file.
- disp_addr  output  ADDR_W  address of the register currently displayed.
- disp_data  output  DATA_W  registered contents of the displayed register.
- disp_valid  output  1  high when disp_addr and disp_data are coherent.
- wrap  output  1  one-cycle pulse when the address wraps (max->0 or 0->max).

Behaviour:
Reset:
- reset_n low, asynchronous: readaddr=0, disp_addr=0, disp_data=0, disp_valid=0, wrap=0.
- Dwell counter=0, synchronizer flops=0, state=SET_ADDR.
- Reset takes effect mid-operation in any state; no partial advance survives.

Step input:
- Passes through a 2-flop synchronizer (s1, s2) plus an edge register s3.
- step_edge = s2 & ~s3, so it asserts exactly one cycle per rising edge.
- Minimum 3 cycles from step rising to step_edge.
- A step held high produces no further edges.

States:
- SET_ADDR: readaddr already holds the target address. Wait one cycle for read settle, then go to SAMPLE. disp_valid=0.
- SAMPLE: on the clock edge, disp_data<=readdata, disp_addr<=readaddr, disp_valid<=1, dwell counter<=0. Go to SHOW.
- SHOW: disp_data<=readdata every cycle, so register writes appear with 1-cycle latency. disp_valid stays 1.

Advance condition (evaluated only in SHOW):
- Advance = step_edge, OR (mode_auto AND dwell counter == DWELL-1).
- Simultaneous step_edge and dwell expiry cause a single advance.
- Dwell counter increments each SHOW cycle while mode_auto=1.
- Dwell counter holds at 0 while mode_auto=0.
- Dwell counter clears on any advance or any change of mode_auto.
- step_edge arriving in SET_ADDR or SAMPLE is dropped, not queued.

On the advance edge:
- readaddr <= readaddr+1 if dir=1, else readaddr-1, modulo 2^ADDR_W.
- disp_valid <= 0; state <= SET_ADDR.
- wrap <= 1 for exactly that following cycle if the transition was 2^ADDR_W-1 -> 0 (dir=1) or 0 -> 2^ADDR_W-1 (dir=0).
- wrap is 0 in all other cycles.

Latency and timing:
- Advance edge to disp_valid re-high with new disp_addr: 2 cycles.
- Auto-mode period per register: DWELL + 2 cycles.
- dir changes take effect at the next advance only.
- disp_addr and disp_data never change while disp_valid=0 (old values are held).

Test Plan:
- Reset: assert reset_n=0 mid-SHOW at addr 7 -> all outputs 0 immediately (asynchronous). Release -> readaddr=0; disp_addr=0, disp_data=mem[0], disp_valid=1 two cycles later.
- Auto scan: DWELL=4, mode_auto=1, dir=1, model mem[i]=i*0x01010101 -> disp_addr steps 0,1,2,... every 6 cycles. Each disp_data matches mem[addr]. wrap=0.
- Wrap up: dir=1, reach addr 31 -> next advance gives readaddr=0 with a single-cycle wrap=1. disp_addr=0, disp_data=0x00000000.
- Manual down-step: mode_auto=0, addr 0, dir=0, one step pulse 10 cycles long -> exactly one advance to 31 with wrap=1. No further advance during the long hold or with no further steps over 1000 cycles.
- Live refresh: in SHOW at addr 30, change model mem[30] from 0x0003FFFF to 0x00012345 -> disp_data=0x00012345 one cycle later. disp_valid stays 1.
- Collision and drop: step_edge on the same cycle as dwell expiry -> addr advances by 1, not 2. step_edge during SET_ADDR -> ignored, address unchanged.
